// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding / hazard controller for the EX-stage operand muxes of the 16-bit,
// 8-register pipeline. A shadow copy of the destination info of the in-flight
// instructions is kept alongside the real pipeline. From it the block computes
// the operand forward selects one cycle early and registers them, so they line
// up with the instruction as it enters EX. It also raises Stall on a load-use
// hazard and sequences the multi-cycle Flush that follows a taken branch.
//
// Ports
//   Clk, Reset          clock (rising edge), asynchronous active-high reset
//   ID_Valid            ID stage holds a real instruction
//   ID_Rs / ID_Rt       source registers feeding Operand1 / Operand2
//   ID_UsesRs/UsesRt    the instruction actually reads Rs / Rt
//   ID_DestReg          destination register (already resolved by RegDst)
//   ID_RegWrite         instruction writes the register file
//   ID_MemRead          instruction is a load
//   BranchTaken         EX resolved a taken branch this cycle
//   ForwardA/ForwardB   operand selects: 00 ReadData1/2, 01 WB_WriteData,
//                       10 Mem_ALUOut (registered)
//   Stall               hold PC and IF/ID, bubble into ID/EX
//   Flush               squash IF/ID and ID/EX
//   StallCount          saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ID_Valid,
   input  logic [2:0]       ID_Rs,
   input  logic [2:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic [2:0]       ID_DestReg,
   input  logic             ID_RegWrite,
   input  logic             ID_MemRead,
   input  logic             BranchTaken,
   output logic [1:0]       ForwardA,
   output logic [1:0]       ForwardB,
   output logic             Stall,
   output logic             Flush,
   output logic [CNT_W-1:0] StallCount
);

   typedef struct packed {
      logic [2:0] dest;
      logic       reg_write;
      logic       mem_read;
   } shadow_t;

   localparam shadow_t Bubble = '0;

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   localparam logic [2:0] CntLoad = 3'(FLUSH_CYCLES - 1);

   // Only the EX and MEM shadow stages are kept: the register file is
   // write-before-read, so the instruction in WB never needs forwarding and
   // its shadow entry would never be looked at.
   shadow_t ex_q, mem_q, ex_d;

   logic [1:0]       fwd_a_q, fwd_a_d;
   logic [1:0]       fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q;
   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;

   logic             flush_raw;
   logic             load_use;
   logic             hit_rs, hit_rt;

   // Forward select for one source; the newer (EX) producer wins over MEM.
   function automatic logic [1:0] fwd_sel(input logic       uses,
                                          input logic [2:0] src,
                                          input shadow_t    ex,
                                          input shadow_t    mem);
      logic [1:0] sel;
      sel = 2'b00;
      if (uses && (src != 3'd0)) begin
         if (ex.reg_write && (ex.dest == src)) begin
            sel = 2'b10;
         end else if (mem.reg_write && (mem.dest == src)) begin
            sel = 2'b01;
         end
      end
      return sel;
   endfunction

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   always_comb begin
      hit_rs   = ID_UsesRs && (ID_Rs != 3'd0) && (ID_Rs == ex_q.dest);
      hit_rt   = ID_UsesRt && (ID_Rt != 3'd0) && (ID_Rt == ex_q.dest);
      load_use = ex_q.mem_read && ex_q.reg_write && (hit_rs || hit_rt);
   end

   // Flush is gated by Reset so it drops the moment Reset rises, even if
   // BranchTaken is still high while the FSM sits in IDLE.
   assign Flush = flush_raw & ~Reset;
   // A taken branch squashes the dependent instruction anyway, so it wins.
   assign Stall = load_use & ~Flush;

   // ---------------------------------------------------------------------------
   // Shadow pipeline and forward selects
   // ---------------------------------------------------------------------------
   always_comb begin
      ex_d = Bubble;
      if (!Stall && !Flush && ID_Valid) begin
         ex_d.dest      = ID_DestReg;
         ex_d.reg_write = ID_RegWrite;
         ex_d.mem_read  = ID_MemRead;
      end
   end

   always_comb begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      // A bubble or a squashed instruction enters EX next cycle: no forwarding.
      if (!Stall && !Flush) begin
         fwd_a_d = fwd_sel(ID_UsesRs, ID_Rs, ex_q, mem_q);
         fwd_b_d = fwd_sel(ID_UsesRt, ID_Rt, ex_q, mem_q);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ex_q    <= Bubble;
         mem_q   <= Bubble;
         fwd_a_q <= 2'b00;
         fwd_b_q <= 2'b00;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign ForwardA = fwd_a_q;
   assign ForwardB = fwd_b_q;

   // ---------------------------------------------------------------------------
   // Stall performance counter (saturating)
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stall_cnt_q <= '0;
      end else if (Stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign StallCount = stall_cnt_q;

   // ---------------------------------------------------------------------------
   // Branch flush sequencer
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      flush_raw = 1'b0;
      unique case (state_q)
         StIdle: begin
            flush_raw = BranchTaken;
            // With a single-cycle window the combinational Flush is enough.
            if (BranchTaken && (FLUSH_CYCLES > 1)) begin
               state_d = StFlush;
               cnt_d   = CntLoad;
            end
         end
         StFlush: begin
            flush_raw = 1'b1;
            if (BranchTaken) begin
               // A fresh taken branch restarts the window.
               cnt_d = CntLoad;
            end else if (cnt_q == 3'd1) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//
// Directed-vector bench. The stimulus process drives one ID-stage instruction
// per cycle and pushes the hand-computed expected outputs for that cycle into
// a scoreboard queue; an independent monitor pops and compares on the falling
// edge. CNT_W is reduced so counter saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

   localparam int unsigned FlushCycles = 2;
   localparam int unsigned CntW        = 4;

   logic            Clk;
   logic            Reset;
   logic            ID_Valid;
   logic [2:0]      ID_Rs;
   logic [2:0]      ID_Rt;
   logic            ID_UsesRs;
   logic            ID_UsesRt;
   logic [2:0]      ID_DestReg;
   logic            ID_RegWrite;
   logic            ID_MemRead;
   logic            BranchTaken;
   logic [1:0]      ForwardA;
   logic [1:0]      ForwardB;
   logic            Stall;
   logic            Flush;
   logic [CntW-1:0] StallCount;

   fwd_hazard_ctrl #(
      .FLUSH_CYCLES (FlushCycles),
      .CNT_W        (CntW)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .ID_Valid    (ID_Valid),
      .ID_Rs       (ID_Rs),
      .ID_Rt       (ID_Rt),
      .ID_UsesRs   (ID_UsesRs),
      .ID_UsesRt   (ID_UsesRt),
      .ID_DestReg  (ID_DestReg),
      .ID_RegWrite (ID_RegWrite),
      .ID_MemRead  (ID_MemRead),
      .BranchTaken (BranchTaken),
      .ForwardA    (ForwardA),
      .ForwardB    (ForwardB),
      .Stall       (Stall),
      .Flush       (Flush),
      .StallCount  (StallCount)
   );

   typedef struct packed {
      logic       v;
      logic [2:0] rs;
      logic [2:0] rt;
      logic       urs;
      logic       urt;
      logic [2:0] rd;
      logic       rw;
      logic       mr;
   } instr_t;

   typedef struct {
      string           nm;
      bit              chk_fwd;
      logic [1:0]      fa;
      logic [1:0]      fb;
      logic            stall;
      logic            flush;
      logic [CntW-1:0] cnt;
   } exp_t;

   exp_t            sb_q[$];
   int              n_vec;
   int              n_err;
   logic [CntW-1:0] exp_cnt;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic instr_t alu(input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
      instr_t i;
      i = '{v: 1'b1, rs: s, rt: t, urs: 1'b1, urt: 1'b1, rd: d, rw: 1'b1, mr: 1'b0};
      return i;
   endfunction

   // Load with base register r0.
   function automatic instr_t lw(input logic [2:0] d);
      instr_t i;
      i = '{v: 1'b1, rs: 3'd0, rt: 3'd0, urs: 1'b1, urt: 1'b0, rd: d, rw: 1'b1, mr: 1'b1};
      return i;
   endfunction

   function automatic instr_t nop();
      instr_t i;
      i = '0;
      return i;
   endfunction

   task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %0h, expected %0h (t=%0t)", nm, fld, act, exp, $time);
      end
   endtask

   // Monitor: checks whatever is pending on each falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp(e.nm, "Stall", 32'(Stall), 32'(e.stall));
            cmp(e.nm, "Flush", 32'(Flush), 32'(e.flush));
            cmp(e.nm, "StallCount", 32'(StallCount), 32'(e.cnt));
            if (e.chk_fwd) begin
               cmp(e.nm, "ForwardA", 32'(ForwardA), 32'(e.fa));
               cmp(e.nm, "ForwardB", 32'(ForwardB), 32'(e.fb));
            end
         end
      end
   end

   // One stimulus cycle. With rm set, Reset is raised mid-cycle and all
   // outputs are expected to be zero before the next rising edge.
   task automatic cyc(input instr_t i, input logic br, input logic es, input logic ef,
                      input bit cf, input logic [1:0] efa, input logic [1:0] efb,
                      input bit rm, input string nm);
      exp_t e;
      @(posedge Clk);
      #1;
      ID_Valid    = i.v;
      ID_Rs       = i.rs;
      ID_Rt       = i.rt;
      ID_UsesRs   = i.urs;
      ID_UsesRt   = i.urt;
      ID_DestReg  = i.rd;
      ID_RegWrite = i.rw;
      ID_MemRead  = i.mr;
      BranchTaken = br;
      if (rm) begin
         #1;
         Reset   = 1'b1;
         exp_cnt = '0;
         e = '{nm: nm, chk_fwd: 1'b1, fa: 2'b00, fb: 2'b00, stall: 1'b0, flush: 1'b0,
               cnt: '0};
         sb_q.push_back(e);
      end else begin
         e = '{nm: nm, chk_fwd: cf, fa: efa, fb: efb, stall: es, flush: ef, cnt: exp_cnt};
         sb_q.push_back(e);
         if (es && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
      end
   endtask

   task automatic release_reset();
      @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   // LW r4 ; ADD r5 <- r4, r1 (stalls once, then is held one more cycle).
   task automatic lu_step(input bit first);
      cyc(lw(3'd4), 1'b0, 1'b0, 1'b0, !first, 2'b01, 2'b00, 1'b0, "lu_lw");
      cyc(alu(3'd5, 3'd4, 3'd1), 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, "lu_stall");
      cyc(alu(3'd5, 3'd4, 3'd1), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, "lu_hold");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      n_vec       = 0;
      n_err       = 0;
      exp_cnt     = '0;
      Reset       = 1'b1;
      ID_Valid    = 1'b0;
      ID_Rs       = 3'd0;
      ID_Rt       = 3'd0;
      ID_UsesRs   = 1'b0;
      ID_UsesRt   = 1'b0;
      ID_DestReg  = 3'd0;
      ID_RegWrite = 1'b0;
      ID_MemRead  = 1'b0;
      BranchTaken = 1'b0;

      // Reset state.
      #1;
      e = '{nm: "reset", chk_fwd: 1'b1, fa: 2'b00, fb: 2'b00, stall: 1'b0, flush: 1'b0,
            cnt: '0};
      sb_q.push_back(e);
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;

      // ALU chain: ADD r2 ; ADD r3 <- r2, r1.
      cyc(alu(3'd2, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "chain_i0");
      cyc(alu(3'd3, 3'd2, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "chain_i1");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, "chain_ex");

      // Double hit on r2 (EX and MEM): newest wins.
      cyc(alu(3'd2, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "dbl_i0");
      cyc(alu(3'd2, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "dbl_i1");
      cyc(alu(3'd6, 3'd1, 3'd2), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "dbl_i2");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, "dbl_ex");

      // Distance-2 only: MEM forward.
      cyc(alu(3'd2, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "d2_i0");
      cyc(alu(3'd7, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "d2_i1");
      cyc(alu(3'd6, 3'd1, 3'd2), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "d2_i2");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, "d2_ex");

      // Load-use: one stall, count 0->1, then ForwardA=01.
      lu_step(1'b1);
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, "lu_ex");

      // r0 source against a load with Dest=0: no stall, no forward.
      e = '{nm: "", chk_fwd: 1'b0, fa: 2'b00, fb: 2'b00, stall: 1'b0, flush: 1'b0, cnt: '0};
      cyc(lw(3'd0), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "r0_lw");
      cyc(alu(3'd5, 3'd0, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "r0_add");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, "r0_ex");

      // Branch: single pulse, then back-to-back pulses.
      cyc(nop(), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "br1_t0");
      cyc(nop(), 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "br1_t1");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "br1_t2");
      cyc(nop(), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "br2_t0");
      cyc(nop(), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "br2_t1");
      cyc(nop(), 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "br2_t2");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "br2_t3");

      // Branch together with load-use: Flush wins, no stall, no count.
      cyc(lw(3'd4), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "brlu_lw");
      cyc(alu(3'd5, 3'd4, 3'd1), 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, "brlu_add");
      cyc(nop(), 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, "brlu_t1");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, "brlu_t2");

      // Reset while ForwardA=10 is on the outputs.
      cyc(alu(3'd2, 3'd1, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "rstf_i0");
      cyc(alu(3'd3, 3'd2, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, "rstf_i1");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, "rst_fwd");
      release_reset();

      // Reset during FLUSH.
      cyc(nop(), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, "rstfl_br");
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, "rst_flush");
      release_reset();
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, "post_rst_idle");

      // Reset during a stall cycle, with StallCount nonzero.
      lu_step(1'b1);
      cyc(lw(3'd4), 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, "rsts_lw");
      cyc(alu(3'd5, 3'd4, 3'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, "rst_stall");
      release_reset();

      // Saturation of StallCount.
      for (int k = 0; k < 17; k++) begin
         lu_step(k == 0);
      end
      cyc(nop(), 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, "sat_end");

      // Drain the scoreboard, bounded.
      for (int k = 0; k < 5; k++) begin
         if (sb_q.size() > 0) @(posedge Clk);
      end
      if (sb_q.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
